ahbl_sram_adapter: RTL

- AHB-Lite slave that fronts one sram_sync instance with BYTE_ENABLE=1, i.e. the stage directly upstream of the memory.
- Reads are zero-wait-state.
- Write data is captured in a one-entry write buffer and committed on the next cycle where the SRAM port is free.
- Reads that hit the buffered write get forwarded bytes. The block sits between the system AHB-Lite crossbar and the on-chip RAM.

---
 rtl/ahbl_sram_adapter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ahbl_sram_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahbl_sram_adapter : AHB-Lite slave for a byte-enabled sync SRAM, zero-wait  |
// | reads, one-entry write buffer with read forwarding.   Revision 1.0          |
// +----------------------------------------------------------------------------+
module ahbl_sram_adapter #(
  parameter int W_DATA      = 32,
  parameter int W_ADDR      = 32,
  parameter int DEPTH       = 2048,
  parameter int W_SRAM_ADDR = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ahbls_hready,
  output logic                   ahbls_hready_resp,
  output logic                   ahbls_hresp,
  input  logic [W_ADDR-1:0]      ahbls_haddr,
  input  logic                   ahbls_hwrite,
  input  logic [1:0]             ahbls_htrans,
  input  logic [2:0]             ahbls_hsize,
  input  logic [2:0]             ahbls_hburst,
  input  logic [3:0]             ahbls_hprot,
  input  logic                   ahbls_hmastlock,
  input  logic [W_DATA-1:0]      ahbls_hwdata,
  output logic [W_DATA-1:0]      ahbls_hrdata,
  output logic [W_SRAM_ADDR-1:0] sram_addr,
  output logic [W_DATA/8-1:0]    sram_wen,
  output logic [W_DATA-1:0]      sram_wdata,
  input  logic [W_DATA-1:0]      sram_rdata
);

  localparam int W_BYTES = W_DATA / 8;

  logic                   dph_read;
  logic                   dph_write;
  logic [W_SRAM_ADDR-1:0] dph_addr;
  logic [W_BYTES-1:0]     dph_mask;

  logic                   wbuf_valid;
  logic [W_SRAM_ADDR-1:0] wbuf_addr;
  logic [W_BYTES-1:0]     wbuf_mask;
  logic [W_DATA-1:0]      wbuf_data;

  logic [W_SRAM_ADDR-1:0] last_addr;
  logic [W_SRAM_ADDR-1:0] sel_addr;
  logic [W_BYTES-1:0]     sel_wen;

  logic                   aph_valid;
  logic                   aph_read;
  logic                   rd_present;
  logic                   stall;
  logic                   wbuf_load;
  logic                   wbuf_drain;
  logic [W_SRAM_ADDR-1:0] word_idx;
  logic [W_BYTES-1:0]     aph_mask;

  logic unused_inputs;
  assign unused_inputs = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0],
                           ahbls_haddr[W_ADDR-1:W_SRAM_ADDR+2], dph_read};

  function automatic logic [3:0] size_mask(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      3'd0:    size_mask = 4'b0001 << lsb;
      3'd1:    size_mask = lsb[1] ? 4'b1100 : 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Gating with rst_n keeps sram_addr at its reset value while reset is held.
  assign aph_valid  = rst_n & ahbls_hready & ahbls_htrans[1];
  assign aph_read   = aph_valid & ~ahbls_hwrite;
  assign rd_present = ahbls_htrans[1] & ~ahbls_hwrite;
  assign word_idx   = ahbls_haddr[W_SRAM_ADDR+1:2];
  assign aph_mask   = size_mask(ahbls_hsize, ahbls_haddr[1:0]);

  // Stall does not look at hready: hready_resp feeds straight back as hready.
  assign stall      = dph_write & wbuf_valid & rd_present;
  assign wbuf_load  = dph_write & ~stall;
  assign wbuf_drain = stall | (wbuf_valid & ~aph_read);

  always_comb begin
    sel_addr = last_addr;
    sel_wen  = '0;
    if (stall) begin
      sel_addr = wbuf_addr;
      sel_wen  = wbuf_mask;
    end else if (aph_read) begin
      sel_addr = word_idx;
    end else if (wbuf_valid) begin
      sel_addr = wbuf_addr;
      sel_wen  = wbuf_mask;
    end
  end

  assign sram_addr         = sel_addr;
  assign sram_wen          = sel_wen;
  assign sram_wdata        = wbuf_data;
  assign ahbls_hready_resp = ~stall;
  assign ahbls_hresp       = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_read   <= 1'b0;
      dph_write  <= 1'b0;
      dph_addr   <= '0;
      dph_mask   <= '0;
      wbuf_valid <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_mask  <= '0;
      wbuf_data  <= '0;
      last_addr  <= '0;
    end else begin
      if (ahbls_hready) begin
        dph_read  <= aph_read;
        dph_write <= aph_valid & ahbls_hwrite;
        dph_addr  <= word_idx;
        dph_mask  <= aph_mask;
      end
      if (wbuf_load) begin
        wbuf_valid <= 1'b1;
        wbuf_addr  <= dph_addr;
        wbuf_mask  <= dph_mask;
        wbuf_data  <= ahbls_hwdata;
      end else if (wbuf_drain) begin
        wbuf_valid <= 1'b0;
      end
      last_addr <= sel_addr;
    end
  end

  // Bytes still sitting in the write buffer are newer than the SRAM copy.
  always_comb begin
    ahbls_hrdata = sram_rdata;
    for (int i = 0; i < W_BYTES; i++) begin
      if (wbuf_valid && wbuf_mask[i] && (wbuf_addr == dph_addr))
        ahbls_hrdata[8*i +: 8] = wbuf_data[8*i +: 8];
    end
  end

endmodule
`default_nettype wire
